// File: rtl/dip_pkg.sv
// Shared types and helpers for the DIP/button event scanner.
package dip_pkg;

   // The event record is sized for the largest supported bank (16 channels).
   // The top module trims the channel field to its own width.
   localparam int unsigned MAX_CHANNELS = 16;
   localparam int unsigned EVT_CHAN_W   = 4;

   typedef struct packed {
      logic [EVT_CHAN_W-1:0] chan;
      logic                  level;
   } dip_evt_t;

   // Priority encoder: index of the lowest set bit, 0 when none are set.
   function automatic logic [EVT_CHAN_W-1:0] lowest_set(input logic [MAX_CHANNELS-1:0] vec);
      logic [EVT_CHAN_W-1:0] idx;
      logic                  found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
         if (vec[i] && !found) begin
            idx   = EVT_CHAN_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/dip_event_fifo.sv
// First-word fall-through event FIFO with occupancy count.
module dip_event_fifo
   import dip_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  dip_evt_t                   push_data,
   input  logic                       pop,
   output dip_evt_t                   head,
   output logic                       head_valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   dip_evt_t          mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   always_comb begin
      head_valid = (count != '0);
      full       = (count == (PTR_W+1)'(DEPTH));
      do_pop     = pop && head_valid;
      do_push    = push && (!full || do_pop);
      head       = head_valid ? mem[rd_ptr] : '0;
   end

   // Storage array; contents need no reset because the head is masked when empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dip_event_scanner.sv
// Raw pin front end: synchronise, debounce, and queue level-change events.
module dip_event_scanner
   import dip_pkg::*;
#(
   parameter int unsigned CHANNELS        = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          ena,
   input  logic [CHANNELS-1:0]                           sw_in,
   output logic [CHANNELS-1:0]                           sw_state,
   output logic                                          evt_valid,
   input  logic                                          evt_ready,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
   output logic                                          evt_level,
   output logic [$clog2(FIFO_DEPTH):0]                   fifo_count,
   output logic                                          overflow,
   input  logic                                          clr_overflow
);

   localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0]   sync1;
   logic [CHANNELS-1:0]   sync2;
   logic [CNT_W-1:0]      cnt [CHANNELS];
   logic [CHANNELS-1:0]   pending;
   logic [CHANNELS-1:0]   qualify;
   logic [CHANNELS-1:0]   push_clear;
   logic [EVT_CHAN_W-1:0] push_idx;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   dip_evt_t              push_data;
   dip_evt_t              head;

   // Two-flop synchroniser; runs regardless of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
      end
   end

   // Qualification, arbitration and push request towards the FIFO.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         qualify[i] = ena && (sync2[i] != sw_state[i]) && (cnt[i] == CNT_LAST);
      end
      pop             = evt_valid && evt_ready;
      push_idx        = lowest_set(MAX_CHANNELS'(pending));
      push            = (|pending) && (!fifo_full || pop);
      push_data.chan  = push_idx;
      push_data.level = sw_state[push_idx];
      push_clear      = '0;
      if (push) begin
         push_clear[push_idx] = 1'b1;
      end
   end

   // Per-channel debounce counter, accepted level and pending-event flag.
   // A re-qualifying channel keeps its pending bit; the push samples sw_state
   // so the queued level is always the latest one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_state <= '0;
         pending  <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!ena || (sync2[i] == sw_state[i])) begin
               cnt[i] <= '0;
            end else if (qualify[i]) begin
               cnt[i]      <= '0;
               sw_state[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
            if (qualify[i]) begin
               pending[i] <= 1'b1;
            end else if (push_clear[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Sticky loss flag: a set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (|(qualify & pending & ~push_clear)) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   dip_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head       (head),
      .head_valid (evt_valid),
      .full       (fifo_full),
      .count      (fifo_count)
   );

   assign evt_chan  = head.chan[CHAN_W-1:0];
   assign evt_level = head.level;

endmodule

// File: tb/tb_dip_event_scanner.sv
// Directed self-checking bench for dip_event_scanner (8 ch, debounce 4, depth 4).
module tb_dip_event_scanner;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] sw_in;
   logic [7:0] sw_state;
   logic       evt_valid;
   logic       evt_ready;
   logic [2:0] evt_chan;
   logic       evt_level;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       clr_overflow;

   int n_assert = 0;
   int n_fail   = 0;

   dip_event_scanner #(
      .CHANNELS        (8),
      .DEBOUNCE_CYCLES (4),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .sw_in        (sw_in),
      .sw_state     (sw_state),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_chan     (evt_chan),
      .evt_level    (evt_level),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // 1: reset with all inputs high, then debounce to 8'hFF
      rst_n = 1'b0; ena = 1'b1; sw_in = 8'hFF; evt_ready = 1'b0; clr_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sw_state",   sw_state,   32'h0);
      check("rst_evt_valid",  evt_valid,  32'h0);
      check("rst_evt_chan",   evt_chan,   32'h0);
      check("rst_evt_level",  evt_level,  32'h0);
      check("rst_fifo_count", fifo_count, 32'h0);
      check("rst_overflow",   overflow,   32'h0);
      rst_n = 1'b1;
      repeat (5) tick();
      check("t1_sw_before", sw_state, 32'h00);
      tick();
      check("t1_sw_after", sw_state, 32'hFF);
      tick();
      check("t1_valid", evt_valid,  32'h1);
      check("t1_chan",  evt_chan,   32'h0);
      check("t1_level", evt_level,  32'h1);
      check("t1_count", fifo_count, 32'h1);

      // 2: fresh reset with inputs low, single rising channel 3
      rst_n = 1'b0; sw_in = 8'h00;
      #1;
      check("t2_rst_count", fifo_count, 32'h0);
      check("t2_rst_valid", evt_valid,  32'h0);
      check("t2_rst_sw",    sw_state,   32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      sw_in = 8'h08;
      repeat (5) tick();
      check("t2_sw_before", sw_state, 32'h00);
      tick();
      check("t2_sw_after",   sw_state,  32'h08);
      check("t2_valid_wait", evt_valid, 32'h0);
      tick();
      check("t2_valid", evt_valid,  32'h1);
      check("t2_chan",  evt_chan,   32'h3);
      check("t2_level", evt_level,  32'h1);
      check("t2_count", fifo_count, 32'h1);
      evt_ready = 1'b1;
      tick();
      check("t2_pop_count", fifo_count, 32'h0);
      check("t2_pop_valid", evt_valid,  32'h0);
      check("t2_pop_chan",  evt_chan,   32'h0);
      evt_ready = 1'b0;

      // 3: three-cycle glitch on channel 5 is rejected
      sw_in = 8'h28;
      repeat (3) tick();
      sw_in = 8'h08;
      repeat (6) tick();
      check("t3_sw",    sw_state,   32'h08);
      check("t3_valid", evt_valid,  32'h0);
      check("t3_count", fifo_count, 32'h0);

      // 4: channels 6 and 1 together, lower index queued first
      sw_in = 8'h4A;
      repeat (6) tick();
      check("t4_sw",         sw_state,  32'h4A);
      check("t4_valid_wait", evt_valid, 32'h0);
      tick();
      check("t4_valid1", evt_valid,  32'h1);
      check("t4_chan1",  evt_chan,   32'h1);
      check("t4_level1", evt_level,  32'h1);
      check("t4_count1", fifo_count, 32'h1);
      tick();
      check("t4_hold_chan", evt_chan,   32'h1);
      check("t4_count2",    fifo_count, 32'h2);
      evt_ready = 1'b1;
      tick();
      check("t4_chan6",  evt_chan,   32'h6);
      check("t4_level6", evt_level,  32'h1);
      check("t4_count3", fifo_count, 32'h1);
      tick();
      check("t4_empty_count", fifo_count, 32'h0);
      check("t4_empty_valid", evt_valid,  32'h0);
      evt_ready = 1'b0;

      // ena low freezes debounce; counting resumes from zero
      ena = 1'b0;
      sw_in = 8'hCA;
      repeat (8) tick();
      check("ena_frozen", sw_state, 32'h4A);
      ena = 1'b1;
      repeat (3) tick();
      check("ena_resume_early", sw_state, 32'h4A);
      tick();
      check("ena_resume", sw_state, 32'hCA);
      evt_ready = 1'b1;
      tick();
      check("ena_valid", evt_valid, 32'h1);
      check("ena_chan",  evt_chan,  32'h7);
      check("ena_level", evt_level, 32'h1);
      tick();
      check("ena_drained", fifo_count, 32'h0);
      evt_ready = 1'b0;

      // 5: toggle ch0..ch4 -> FIFO fills, ch4 waits; retoggle ch4 -> overflow
      sw_in = 8'hD5;
      repeat (6) tick();
      check("t5_sw", sw_state, 32'hD5);
      tick();
      check("t5_count1", fifo_count, 32'h1);
      check("t5_chan0",  evt_chan,   32'h0);
      check("t5_level0", evt_level,  32'h1);
      repeat (3) tick();
      check("t5_count4",   fifo_count, 32'h4);
      check("t5_head_hold", evt_chan,  32'h0);
      tick();
      check("t5_full_count", fifo_count, 32'h4);
      check("t5_no_ovf",     overflow,   32'h0);
      sw_in = 8'hC5;
      repeat (5) tick();
      check("t5_ovf_before", overflow, 32'h0);
      tick();
      check("t5_ovf_set",  overflow, 32'h1);
      check("t5_sw_retog", sw_state, 32'hC5);
      clr_overflow = 1'b1;
      tick();
      check("t5_ovf_clr", overflow, 32'h0);
      clr_overflow = 1'b0;

      // 6: full FIFO, pop and push in one cycle; then async reset mid-stream
      evt_ready = 1'b1;
      tick();
      check("t6_count", fifo_count, 32'h4);
      check("t6_valid", evt_valid,  32'h1);
      check("t6_chan",  evt_chan,   32'h1);
      check("t6_level", evt_level,  32'h0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", evt_valid,  32'h0);
      check("t6_rst_count", fifo_count, 32'h0);
      check("t6_rst_sw",    sw_state,   32'h0);
      check("t6_rst_ovf",   overflow,   32'h0);
      check("t6_rst_chan",  evt_chan,   32'h0);
      evt_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
